pending_priority_encoder: RTL and testbench

- Registered N-to-log2(N) priority encoder with request capture, the encoding counterpart of the team's 3-to-8 line decoder.
- Captures single-cycle request pulses on N lines into a pending register.
- Emits the index of the highest-numbered pending line over a valid/ready handshake, and retires each line once its code is accepted.
- Sits between event sources (decoded strobes, interrupt lines) and a consumer that services one event index at a time.

---
 rtl/pending_priority_encoder_pkg.sv | 16 +
 rtl/pending_priority_encoder_prio_enc_comb.sv | 22 ++
 rtl/pending_priority_encoder.sv | 78 +++++++
 tb/tb_pending_priority_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pending_priority_encoder_pkg.sv
// Shared constants and helpers for the pending priority encoder.
package pending_priority_encoder_pkg;

  // Default number of request lines and the matching code width.
  localparam int REQ_N  = 8;
  localparam int CODE_W = $clog2(REQ_N);

  // One-hot decode of a code index; used to build the retire mask.
  function automatic logic [REQ_N-1:0] onehot(input logic [CODE_W-1:0] c);
    logic [REQ_N-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_enc_comb.sv
// Combinational highest-set-bit encoder.
module prio_enc_comb
  import pending_priority_encoder_pkg::*;
#(
  parameter int N = REQ_N,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] v,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan upward so the last (highest) set bit overrides lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    any = |v;
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Pending-request capture register feeding a registered priority encoder
// with a valid/ready output. Highest index wins, no preemption of an
// offered code, each line retired when its code is accepted.
module pending_priority_encoder
  import pending_priority_encoder_pkg::*;
#(
  parameter int N = REQ_N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic [N-1:0] pend,
  output logic         dup
);

  logic         transfer;
  logic         out_free;
  logic [N-1:0] clr_sel;
  logic [N-1:0] clr;
  logic [N-1:0] pend_next;
  logic         dup_hit;
  logic [W-1:0] enc_idx;
  logic         enc_any;

  // One-hot of the offered code; the package helper covers the default width.
  generate
    if (N == REQ_N) begin : g_pkg_onehot
      assign clr_sel = onehot(code);
    end else begin : g_shift_onehot
      assign clr_sel = {{(N-1){1'b0}}, 1'b1} << code;
    end
  endgenerate

  // Handshake, retire mask, next pending vector and duplicate detection.
  always_comb begin
    transfer  = code_valid & code_ready;
    out_free  = ~code_valid | transfer;
    clr       = transfer ? clr_sel : '0;
    // A line retired and re-requested in the same cycle stays pending.
    pend_next = (pend & ~clr) | d;
    // Re-requesting the line being retired is not a duplicate.
    dup_hit   = |(d & pend & ~clr);
  end

  // Encoder looks at the post-update vector so the next code loads at the
  // same edge as the transfer, without a bubble.
  prio_enc_comb #(
    .N (N),
    .W (W)
  ) u_prio_enc (
    .v   (pend_next),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Pending register, sticky dup flag and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      dup        <= 1'b0;
      code_valid <= 1'b0;
      code       <= '0;
    end else begin
      pend <= pend_next;
      if (dup_hit) dup <= 1'b1;
      // Output register only reloads when free; a stalled code is held.
      if (out_free) begin
        code_valid <= enc_any;
        if (enc_any) code <= enc_idx;
      end
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Scoreboard bench for pending_priority_encoder: directed cases plus a
// random soak against a set-based reference model.
module tb_pending_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] d;
  logic [W-1:0] code;
  logic         code_valid;
  logic         code_ready;
  logic [N-1:0] pend;
  logic         dup;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: set of pending lines, currently offered line (-1 none).
  bit mpend [N];
  int moff;
  bit mdup;
  int exp_q [$];

  pending_priority_encoder #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pend       (pend),
    .dup        (dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_pend();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = mpend[i];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, advance the model, push expected transfers,
  // then compare the post-edge state with the model.
  task automatic step(input logic [N-1:0] dv, input logic rdy, input logic r);
    bit xfer;
    @(negedge clk);
    #1;
    d          = dv;
    code_ready = r ? 1'b0 : rdy;
    rst        = r;
    if (r) begin
      for (int i = 0; i < N; i++) mpend[i] = 0;
      moff = -1;
      mdup = 0;
    end else begin
      xfer = (moff >= 0) && rdy;
      if (xfer) exp_q.push_back(moff);
      for (int i = 0; i < N; i++)
        if (dv[i] && mpend[i] && !(xfer && i == moff)) mdup = 1;
      if (xfer) mpend[moff] = 0;
      for (int i = 0; i < N; i++) if (dv[i]) mpend[i] = 1;
      if (moff < 0 || xfer) begin
        moff = -1;
        for (int i = 0; i < N; i++) if (mpend[i]) moff = i;
      end
    end
    @(posedge clk);
    #1;
    chk("pend", int'(pend), int'(model_pend()));
    chk("code_valid", int'(code_valid), (moff >= 0) ? 1 : 0);
    if (moff >= 0) chk("code", int'(code), moff);
    chk("dup", int'(dup), int'(mdup));
  endtask

  // Monitor: pop and compare on every observed transfer; check invariant.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #3;
      if (code_valid === 1'b1) begin
        n_cmp++;
        if (pend[code] !== 1'b1) begin
          n_err++;
          $display("FAIL invariant: pend[%0d]=%b required 1 at %0t", code, pend[code], $time);
        end
        if (code_ready === 1'b1 && rst === 1'b0) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL xfer_code: got %0d with nothing expected at %0t", code, $time);
          end else begin
            e = exp_q.pop_front();
            if (int'(code) != e) begin
              n_err++;
              $display("FAIL xfer_code: got %0d expected %0d at %0t", code, e, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rd;
    rst = 1'b1; d = '0; code_ready = 1'b0;
    moff = -1; mdup = 0;
    for (int i = 0; i < N; i++) mpend[i] = 0;

    // Reset after a full request word.
    step(8'h00, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    chk("rst_pend", int'(pend), 0);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_dup", int'(dup), 0);

    // Burst drain 7,5,2,0.
    step(8'hA5, 1'b1, 1'b0);
    chk("burst_c7", int'(code), 7); chk("burst_p0", int'(pend), 'hA5);
    step(8'h00, 1'b1, 1'b0);
    chk("burst_c5", int'(code), 5); chk("burst_p1", int'(pend), 'h25);
    step(8'h00, 1'b1, 1'b0);
    chk("burst_c2", int'(code), 2); chk("burst_p2", int'(pend), 'h05);
    step(8'h00, 1'b1, 1'b0);
    chk("burst_c0", int'(code), 0); chk("burst_p3", int'(pend), 'h01);
    step(8'h00, 1'b1, 1'b0);
    chk("burst_empty", int'(code_valid), 0); chk("burst_p4", int'(pend), 0);

    // Stall without preemption.
    step(8'h02, 1'b0, 1'b0);
    chk("stall_c1", int'(code), 1);
    step(8'h00, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    chk("stall_hold", int'(code), 1); chk("stall_pend", int'(pend), 'h82);
    step(8'h00, 1'b1, 1'b0);
    chk("stall_c7", int'(code), 7); chk("stall_v", int'(code_valid), 1);
    step(8'h00, 1'b1, 1'b0);
    chk("stall_empty", int'(code_valid), 0);

    // Retire and re-request in the same cycle.
    step(8'h10, 1'b1, 1'b0);
    chk("rr_c4", int'(code), 4);
    step(8'h10, 1'b1, 1'b0);
    chk("rr_pend", int'(pend), 'h10); chk("rr_c4b", int'(code), 4);
    chk("rr_v", int'(code_valid), 1); chk("rr_dup", int'(dup), 0);
    step(8'h00, 1'b1, 1'b0);
    chk("rr_empty", int'(code_valid), 0);

    // Duplicate on a pending, non-offered line; sticky until reset.
    step(8'h48, 1'b0, 1'b0);
    chk("dup_c6", int'(code), 6); chk("dup_pre", int'(dup), 0);
    step(8'h08, 1'b0, 1'b0);
    chk("dup_set", int'(dup), 1);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    chk("dup_sticky", int'(dup), 1);
    step(8'h00, 1'b0, 1'b1);
    chk("dup_clr", int'(dup), 0);

    // Random soak with sparse requests and an occasional reset.
    for (int k = 0; k < 10000; k++) begin
      rd = N'($urandom & $urandom & $urandom);
      step(rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 999) == 0));
    end

    // Drain and confirm every expected transfer was observed.
    for (int k = 0; k < N + 2; k++) step(8'h00, 1'b1, 1'b0);
    chk("drain_valid", int'(code_valid), 0);
    chk("queue_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
